// File: rtl/cnn_pkg.sv
// cnn_pkg: shared widths, saturation bounds and the output clamp for the 5x5 MAC.
package cnn_pkg;
  localparam int PIX_W = 8;
  localparam int COEF_W = 8;
  localparam int PROD_W = 17;
  localparam int ACC_W = 22;
  localparam int KSIZE = 5;
  localparam int KTAPS = 25;
  localparam logic [4:0] LAST_IDX = 5'(KTAPS - 1);
  localparam logic signed [ACC_W-1:0] RELU_LO = 0;
  localparam logic signed [ACC_W-1:0] RELU_HI = 255;
  localparam logic signed [ACC_W-1:0] TC_LO = -128;
  localparam logic signed [ACC_W-1:0] TC_HI = 127;

  function automatic logic [PIX_W-1:0] sat8(input logic signed [ACC_W-1:0] x, input bit relu);
    logic signed [ACC_W-1:0] lo, hi, y;
    lo = relu ? RELU_LO : TC_LO;
    hi = relu ? RELU_HI : TC_HI;
    y = x < lo ? lo : x > hi ? hi : x;
    return y[PIX_W-1:0];
  endfunction
endpackage

// File: rtl/mac5_row.sv
// mac5_row: one kernel row, five registered pixel x coefficient products then a registered row sum.
module mac5_row
  import cnn_pkg::*;
(
  input  logic                            i_clk,
  input  logic [KSIZE-1:0][PIX_W-1:0]     i_pix,
  input  logic [KSIZE-1:0][COEF_W-1:0]    i_coef,
  output logic signed [ACC_W-1:0]         o_sum
);
  logic signed [PROD_W-1:0] r_prod [KSIZE];
  logic signed [ACC_W-1:0] w_sum;

  // pixels are unsigned, so a zero MSB keeps them positive in the signed multiply
  always_ff @(posedge i_clk)
    for (int k = 0; k < KSIZE; k++)
      r_prod[k] <= $signed({1'b0, i_pix[k]}) * $signed(i_coef[k]);

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < KSIZE; k++)
      w_sum = w_sum + ACC_W'(r_prod[k]);
  end

  always_ff @(posedge i_clk) o_sum <= w_sum;
endmodule

// File: rtl/conv5x5_mac.sv
// conv5x5_mac: serially loaded 5x5 signed kernel, four-stage MAC with bias, shift and clamp.
module conv5x5_mac
  import cnn_pkg::*;
#(
  parameter int SHIFT = 8,
  parameter bit RELU_EN = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_w_load,
  input  logic [COEF_W-1:0] i_w_data,
  output logic              o_w_ready,
  input  logic [15:0]       i_bias,
  input  logic              i_win_en,
  input  logic [PIX_W-1:0]  i_c0_0, i_c0_1, i_c0_2, i_c0_3, i_c0_4,
  input  logic [PIX_W-1:0]  i_c1_0, i_c1_1, i_c1_2, i_c1_3, i_c1_4,
  input  logic [PIX_W-1:0]  i_c2_0, i_c2_1, i_c2_2, i_c2_3, i_c2_4,
  input  logic [PIX_W-1:0]  i_c3_0, i_c3_1, i_c3_2, i_c3_3, i_c3_4,
  input  logic [PIX_W-1:0]  i_c4_0, i_c4_1, i_c4_2, i_c4_3, i_c4_4,
  output logic              o_valid,
  output logic [PIX_W-1:0]  o_data,
  output logic              o_drop_err
);
  logic [KTAPS-1:0][COEF_W-1:0] r_coef;
  logic [4:0] r_idx;
  logic [KTAPS-1:0][PIX_W-1:0] w_pix;
  logic w_acc;
  logic signed [ACC_W-1:0] w_row [KSIZE];
  logic signed [ACC_W-1:0] r_tot, w_sh;
  logic [2:0] r_v;

  assign w_pix = {i_c4_4, i_c4_3, i_c4_2, i_c4_1, i_c4_0,
                  i_c3_4, i_c3_3, i_c3_2, i_c3_1, i_c3_0,
                  i_c2_4, i_c2_3, i_c2_2, i_c2_1, i_c2_0,
                  i_c1_4, i_c1_3, i_c1_2, i_c1_1, i_c1_0,
                  i_c0_4, i_c0_3, i_c0_2, i_c0_1, i_c0_0};
  assign w_acc = i_win_en & o_w_ready;
  assign w_sh = r_tot >>> SHIFT;

  genvar r;
  for (r = 0; r < KSIZE; r++) begin : g_row
    mac5_row u_row (
      .i_clk  (i_clk),
      .i_pix  (w_pix[r*KSIZE +: KSIZE]),
      .i_coef (r_coef[r*KSIZE +: KSIZE]),
      .o_sum  (w_row[r])
    );
  end

  // a load while ready restarts the kernel at tap 0
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_coef <= '0;
      r_idx <= '0;
      o_w_ready <= 1'b0;
      o_drop_err <= 1'b0;
    end else begin
      if (i_win_en && !o_w_ready) o_drop_err <= 1'b1;
      if (i_w_load) begin
        r_coef[o_w_ready ? 5'd0 : r_idx] <= i_w_data;
        r_idx <= o_w_ready ? 5'd1 : r_idx == LAST_IDX ? 5'd0 : r_idx + 5'd1;
        o_w_ready <= !o_w_ready && r_idx == LAST_IDX;
      end
    end
  end

  always_ff @(posedge i_clk)
    r_tot <= w_row[0] + w_row[1] + w_row[2] + w_row[3] + w_row[4] + ACC_W'($signed(i_bias));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_v <= '0;
      o_valid <= 1'b0;
      o_data <= '0;
    end else begin
      r_v <= {r_v[1:0], w_acc};
      o_valid <= r_v[2];
      if (r_v[2]) o_data <= sat8(w_sh, RELU_EN);
    end
  end
endmodule
